// File: rtl/simple_processor_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// simple_processor_pkg : opcode/step enums and instruction-field helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
package simple_processor_pkg;

    localparam int c_OP_W = 3;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MVI  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_MVNZ = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    function automatic int op_msb(input int dw);
        return dw - 1;
    endfunction

    function automatic int rx_msb(input int dw);
        return dw - 1 - c_OP_W;
    endfunction

    function automatic int ry_msb(input int dw, input int rw);
        return dw - 1 - c_OP_W - rw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sp_alu : combinational ALU (add/sub/and/or/xor) with zero and carry flags
// Revision: 1.0
// ---------------------------------------------------------------------------
module sp_alu
    import simple_processor_pkg::*;
#(
    parameter int DW = 9
) (
    input  op_t           op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          z,
    output logic          c
);

    logic [DW:0] w_sum;
    logic [DW:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    // The extra top bit of the difference is the borrow, i.e. a < b.
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = b;
        c      = 1'b0;
        case (op)
            OP_ADD: begin
                result = w_sum[DW-1:0];
                c      = w_sum[DW];
            end
            OP_SUB: begin
                result = w_diff[DW-1:0];
                c      = w_diff[DW];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = b;
        endcase
    end

    assign z = (result == '0);

endmodule
`default_nettype wire

// File: rtl/simple_processor_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// simple_processor_param : parametrised multicycle processor, T0..T3 over a shared bus
// Revision: 1.0
// ---------------------------------------------------------------------------
module simple_processor_param
    import simple_processor_pkg::*;
#(
    parameter int DW   = 9,
    parameter int NREG = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    output logic [DW-1:0] Bus,
    output logic          Done,
    output logic          Zflag,
    output logic          Cflag
);

    localparam int RW       = $clog2(NREG);
    localparam int c_OP_MSB = op_msb(DW);
    localparam int c_RX_MSB = rx_msb(DW);
    localparam int c_RY_MSB = ry_msb(DW, RW);

    step_t         r_step;
    step_t         w_step_nxt;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_g;
    logic [DW-1:0] r_regs [NREG];
    logic          r_z;
    logic          r_c;

    op_t           w_op;
    logic [RW-1:0] w_rx;
    logic [RW-1:0] w_ry;
    logic [DW-1:0] w_bus;
    logic          w_done;
    logic          w_wr_en;
    logic          w_a_en;
    logic          w_g_en;
    logic [DW-1:0] w_alu_res;
    logic          w_alu_z;
    logic          w_alu_c;
    logic          w_unused_ir;

    assign w_op        = op_t'(r_ir[c_OP_MSB -: c_OP_W]);
    assign w_rx        = r_ir[c_RX_MSB -: RW];
    assign w_ry        = r_ir[c_RY_MSB -: RW];
    assign w_unused_ir = ^r_ir;

    sp_alu #(
        .DW (DW)
    ) u_alu (
        .op     (w_op),
        .a      (r_a),
        .b      (w_bus),
        .result (w_alu_res),
        .z      (w_alu_z),
        .c      (w_alu_c)
    );

    always_comb begin
        w_step_nxt = r_step;
        w_bus      = '0;
        w_done     = 1'b0;
        w_wr_en    = 1'b0;
        w_a_en     = 1'b0;
        w_g_en     = 1'b0;
        case (r_step)
            T0: begin
                if (Run) begin
                    w_step_nxt = T1;
                end
            end
            T1: begin
                case (w_op)
                    OP_MV: begin
                        w_bus      = r_regs[w_ry];
                        w_wr_en    = 1'b1;
                        w_done     = 1'b1;
                        w_step_nxt = T0;
                    end
                    OP_MVI: begin
                        w_bus      = DIN;
                        w_wr_en    = 1'b1;
                        w_done     = 1'b1;
                        w_step_nxt = T0;
                    end
                    OP_MVNZ: begin
                        // Conditional move keys off the flag left by the last ALU op.
                        if (!r_z) begin
                            w_bus   = r_regs[w_ry];
                            w_wr_en = 1'b1;
                        end
                        w_done     = 1'b1;
                        w_step_nxt = T0;
                    end
                    default: begin
                        w_bus      = r_regs[w_rx];
                        w_a_en     = 1'b1;
                        w_step_nxt = T2;
                    end
                endcase
            end
            T2: begin
                w_bus      = r_regs[w_ry];
                w_g_en     = 1'b1;
                w_step_nxt = T3;
            end
            T3: begin
                w_bus      = r_g;
                w_wr_en    = 1'b1;
                w_done     = 1'b1;
                w_step_nxt = T0;
            end
            default: w_step_nxt = T0;
        endcase
        if (Reset) begin
            w_bus  = '0;
            w_done = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_step <= T0;
            r_ir   <= '0;
            r_a    <= '0;
            r_g    <= '0;
            r_z    <= 1'b0;
            r_c    <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_step <= w_step_nxt;
            if (r_step == T0 && Run) begin
                r_ir <= DIN;
            end
            if (w_a_en) begin
                r_a <= w_bus;
            end
            if (w_g_en) begin
                r_g <= w_alu_res;
                r_z <= w_alu_z;
                r_c <= w_alu_c;
            end
            if (w_wr_en) begin
                r_regs[w_rx] <= w_bus;
            end
        end
    end

    assign Bus   = w_bus;
    assign Done  = w_done;
    assign Zflag = r_z;
    assign Cflag = r_c;

endmodule
`default_nettype wire
